fm_mod32: RTL and testbench
===========================

// Module: fm_mod32
// PURPOSE
//  FM modulator: transmit-side counterpart of the FM conjugate-product discriminator.
//  Accepts a signed audio/deviation sample stream on AXI-Stream.
//  Integrates each sample into a phase accumulator (NCO).
//  Emits unit-amplitude complex baseband I/Q on AXI-Stream, ready for the DAC/upconverter path.
// PARAMETERS
//  C_S00_AXIS_TDATA_WIDTH  32          input bus width; [15:0] = signed sample, [31:16] ignored
//  C_M00_AXIS_TDATA_WIDTH  32          output bus width; [15:0] = I, [31:16] = Q (signed)
//  PHASE_W                 32          phase accumulator width (full turn = 2^PHASE_W)
//  LUT_AW                  10          quarter-wave table address bits; phase index = top LUT_AW+2 bits
//  DEV_SHIFT               8           sample left-shift into phase increment (deviation gain)
//  CENTER_INC              32'h0       constant phase increment added every sample (carrier offset)
//  AMP                     32000       output amplitude; must be <= 32767
// PORTS
//  s00_axis_aclk     in   1        single clock
//  s00_axis_areset   in   1        synchronous, active-high reset
//  s00_axis_tvalid   in   1        input beat valid
//  s00_axis_tready   out  1        input ready
//  s00_axis_tlast    in   1        input end-of-packet
//  s00_axis_tdata    in   32       [15:0] signed sample
//  s00_axis_tstrb    in   4        ignored
//  m00_axis_tvalid   out  1        output beat valid
//  m00_axis_tready   in   1        downstream ready
//  m00_axis_tlast    out  1        tlast of the corresponding input beat
//  m00_axis_tdata    out  32       {Q[15:0], I[15:0]}
//  m00_axis_tstrb    out  4        4'hF whenever tvalid; 0 in reset
// BEHAVIOUR
//  - Reset (sync, active-high): phase_acc=0, all stage valids=0.
//    Output reset values: m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, m00_axis_tstrb=0.
//    A reset asserted mid-stream drops all in-flight beats; the next accepted sample starts from phase 0.
//  - Pipeline enable: en = !m00_axis_tvalid || m00_axis_tready; s00_axis_tready = en (combinational).
//  - en=0: every stage register and phase_acc hold. No beat is lost or duplicated.
//    tdata/tlast stay stable while tvalid=1 && !tready.
//  - Accepted beat n (tvalid && tready) carries sample x_n:
//    inc_n = CENTER_INC + (sext(x_n) <<< DEV_SHIFT), mod 2^PHASE_W.
//    phi_n = phi_{n-1} + inc_n (mod 2^PHASE_W), with phi_{-1}=0 after reset.
//    Beat n's output uses the updated phase phi_n.
//  - idx_n = phi_n[PHASE_W-1 -: LUT_AW+2] (truncation, no rounding).
//    I = round(AMP*cos(2*pi*idx_n/2^(LUT_AW+2))); Q = round(AMP*sin(same)).
//    Output must be bit-exact to this; round half away from zero.
//    Either a quarter-wave ROM with quadrant fold/negate or a full table is acceptable.
//  - Stages: S1 phase accumulate; S2 ROM read (registered, BRAM-inferable); S3 quadrant sign fix into output regs.
//    Latency 3 cycles: a beat accepted at edge k appears with m00_axis_tvalid=1 after edge k+2 when unstalled.
//  - Throughput 1 beat/clk when m00_axis_tready=1.
//  - Idle cycles (en=1, no input beat) insert bubbles: phase does not advance and no output is produced.
//  - tlast travels with its beat through all stages. Sample width is fixed at 16 regardless of bus width.
// CONFIGURATION
//  FM_MOD_TLAST_PHASE_RST_EN defined:
//    after accepting a beat with s00_axis_tlast=1, phase_acc is forced to 0 (that beat still outputs phi_n).
//    Every packet's first sample starts from phase 0.
//  FM_MOD_TLAST_PHASE_RST_EN undefined:
//    phase is continuous across packets; tlast only passes through.
// TESTING
//  1 Defaults, 8 beats x=0 -> 8 outputs I=32000, Q=0; tstrb=4'hF.
//  2 DEV_SHIFT=16, x=16'h4000 x4 -> (I,Q) = (0,32000), (-32000,0), (0,-32000), (32000,0);
//    x=16'hC000 x1 afterwards -> (0,-32000).
//  3 Defaults, x=16'h4000 streamed -> idx steps by 4 per beat;
//    beat1 I=round(32000*cos(2*pi*4/4096)) = 31999, Q=round(32000*sin(2*pi*4/4096)) = 196.
//  4 Random m00_axis_tready (50%), 1000 random samples
//    -> output sequence identical to golden model; tdata stable while stalled; no drop or duplicate.
//  5 tlast on beat 5 of 10 -> m00_axis_tlast on output 5 only.
//    With FM_MOD_TLAST_PHASE_RST_EN, output 6 equals the fresh-reset response for x_6.
//  6 Assert s00_axis_areset for 1 cycle with 3 beats in flight
//    -> tvalid=0 next cycle; next sample x=0 gives I=32000, Q=0.

Source files
------------

// File: rtl/fm_mod32_if.sv
// -----------------------------------------------------------------------------
// fm_mod32_if : AXI-Stream beat bundle used on both sides of the FM modulator.
//
//   tvalid  beat valid            (master -> slave)
//   tready  sink ready            (slave  -> master)
//   tlast   end of packet         (master -> slave)
//   tdata   payload, DATA_W bits  (master -> slave)
//   tstrb   byte strobes          (master -> slave)
//
// Modports: master drives the beat and samples tready, slave the reverse.
// -----------------------------------------------------------------------------
interface fm_mod32_if #(
  parameter int DATA_W = 32
) ();
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;

  modport master (output tvalid, output tlast, output tdata, output tstrb, input tready);
  modport slave  (input tvalid, input tlast, input tdata, input tstrb, output tready);
endinterface

// File: rtl/fm_mod32.sv
// -----------------------------------------------------------------------------
// fm_mod32 : FM modulator. Each accepted signed 16-bit sample is scaled into a
// phase increment, integrated in an NCO phase accumulator, and the resulting
// phase is mapped to a unit-amplitude complex sample {Q, I} via a quarter-wave
// sine table with quadrant folding.
//
// Ports
//   s00_axis_aclk    clock
//   s00_axis_areset  synchronous active-high reset
//   s00_axis         slave stream,  tdata[15:0] = signed sample (rest ignored)
//   m00_axis         master stream, tdata = {Q[15:0], I[15:0]}, tstrb = all ones
//
// Pipeline: S1 phase accumulate -> S2 registered table read -> S3 sign fix
// into the output registers (3 cycles, one beat per clock). All stages advance
// together on en = !m00_axis.tvalid || m00_axis.tready.
//
// Build option: define FM_MOD_TLAST_PHASE_RST_EN to restart the phase at zero
// after every beat that carries tlast (the tlast beat itself still uses its
// own updated phase). Undefined: phase is continuous across packets.
// -----------------------------------------------------------------------------
module fm_mod32 #(
  parameter int                 C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int                 C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int                 PHASE_W                = 32,
  parameter int                 LUT_AW                 = 10,
  parameter int                 DEV_SHIFT              = 8,
  parameter logic [PHASE_W-1:0] CENTER_INC             = 32'h0,
  parameter int                 AMP                    = 32000
) (
  input  logic       s00_axis_aclk,
  input  logic       s00_axis_areset,
  fm_mod32_if.slave  s00_axis,
  fm_mod32_if.master m00_axis
);

  localparam int  IDX_W  = LUT_AW + 2;
  localparam int  QN     = 1 << LUT_AW;
  localparam int  STRB_W = C_M00_AXIS_TDATA_WIDTH / 8;
  localparam real PI     = 3.14159265358979323846;

  // Quarter-wave table: entry a = round(AMP * sin(pi/2 * a/QN)), a = 0..QN.
  // Entry QN is needed because the cosine read uses address QN - a.
  logic [15:0] quarter_rom [0:QN];
  for (genvar a = 0; a <= QN; a++) begin : g_rom
    localparam real ANG = PI * real'(a) / (2.0 * real'(QN));
    localparam int  VAL = $rtoi(real'(AMP) * $sin(ANG) + 0.5);
    assign quarter_rom[a] = VAL[15:0];
  end

  // S1 state
  logic [PHASE_W-1:0] phase_acc_q, phase_acc_d;
  logic [IDX_W-1:0]   idx1_q, idx1_d;
  logic               v1_q, v1_d;
  logic               last1_q, last1_d;
  // S2 state
  logic [15:0]        rom_a_q, rom_a_d;
  logic [15:0]        rom_b_q, rom_b_d;
  logic [1:0]         quad2_q, quad2_d;
  logic               v2_q, v2_d;
  logic               last2_q, last2_d;
  // S3 / output state
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [STRB_W-1:0]  tstrb_q, tstrb_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;

  logic                      en_s;
  logic                      accept_s;
  logic signed [PHASE_W-1:0] samp_ext_s;
  logic [PHASE_W-1:0]        inc_s;
  logic [PHASE_W-1:0]        phi_next_s;
  logic [LUT_AW:0]           addr_b_s;
  logic [15:0]               neg_a_s;
  logic [15:0]               neg_b_s;
  logic [15:0]               i_s;
  logic [15:0]               q_s;
  logic                      unused_ok;

  assign en_s            = !tvalid_q || m00_axis.tready;
  assign accept_s        = en_s && s00_axis.tvalid;
  assign s00_axis.tready = en_s;

  assign m00_axis.tvalid = tvalid_q;
  assign m00_axis.tlast  = tlast_q;
  assign m00_axis.tdata  = tdata_q;
  assign m00_axis.tstrb  = tstrb_q;

  assign unused_ok = ^{s00_axis.tdata[C_S00_AXIS_TDATA_WIDTH-1:16], s00_axis.tstrb};

  // Phase increment and next phase for the sample currently on the input.
  always_comb begin
    samp_ext_s = {{(PHASE_W-16){s00_axis.tdata[15]}}, s00_axis.tdata[15:0]};
    inc_s      = CENTER_INC + (samp_ext_s <<< DEV_SHIFT);
    phi_next_s = phase_acc_q + inc_s;
  end

  // Quadrant fold: map the two table reads (sin(a), sin(QN-a)=cos(a)) to I/Q.
  always_comb begin
    neg_a_s = 16'd0 - rom_a_q;
    neg_b_s = 16'd0 - rom_b_q;
    i_s     = rom_b_q;
    q_s     = rom_a_q;
    case (quad2_q)
      2'd0: begin i_s = rom_b_q; q_s = rom_a_q; end
      2'd1: begin i_s = neg_a_s; q_s = rom_b_q; end
      2'd2: begin i_s = neg_b_s; q_s = neg_a_s; end
      2'd3: begin i_s = rom_a_q; q_s = neg_b_s; end
      default: begin i_s = rom_b_q; q_s = rom_a_q; end
    endcase
  end

  // Next-state for all stages; everything holds while the output is stalled.
  always_comb begin
    phase_acc_d = phase_acc_q;
    idx1_d      = idx1_q;
    v1_d        = v1_q;
    last1_d     = last1_q;
    rom_a_d     = rom_a_q;
    rom_b_d     = rom_b_q;
    quad2_d     = quad2_q;
    v2_d        = v2_q;
    last2_d     = last2_q;
    tdata_d     = tdata_q;
    tstrb_d     = tstrb_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    addr_b_s    = QN[LUT_AW:0] - {1'b0, idx1_q[LUT_AW-1:0]};
    if (en_s) begin
      // S1: a bubble leaves the phase untouched
      v1_d    = s00_axis.tvalid;
      last1_d = s00_axis.tvalid && s00_axis.tlast;
      if (accept_s) begin
        idx1_d = phi_next_s[PHASE_W-1 -: IDX_W];
`ifdef FM_MOD_TLAST_PHASE_RST_EN
        phase_acc_d = s00_axis.tlast ? {PHASE_W{1'b0}} : phi_next_s;
`else
        phase_acc_d = phi_next_s;
`endif
      end else begin
        idx1_d      = idx1_q;
        phase_acc_d = phase_acc_q;
      end
      // S2: registered table read
      rom_a_d = quarter_rom[idx1_q[LUT_AW-1:0]];
      rom_b_d = quarter_rom[addr_b_s];
      quad2_d = idx1_q[IDX_W-1 -: 2];
      v2_d    = v1_q;
      last2_d = last1_q;
      // S3: output registers
      tvalid_d = v2_q;
      tlast_d  = v2_q && last2_q;
      tdata_d  = v2_q ? C_M00_AXIS_TDATA_WIDTH'({q_s, i_s}) : {C_M00_AXIS_TDATA_WIDTH{1'b0}};
      tstrb_d  = v2_q ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
    end else begin
      phase_acc_d = phase_acc_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      phase_acc_q <= {PHASE_W{1'b0}};
      idx1_q      <= {IDX_W{1'b0}};
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      rom_a_q     <= 16'd0;
      rom_b_q     <= 16'd0;
      quad2_q     <= 2'd0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      tdata_q     <= {C_M00_AXIS_TDATA_WIDTH{1'b0}};
      tstrb_q     <= {STRB_W{1'b0}};
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      phase_acc_q <= phase_acc_d;
      idx1_q      <= idx1_d;
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      rom_a_q     <= rom_a_d;
      rom_b_q     <= rom_b_d;
      quad2_q     <= quad2_d;
      v2_q        <= v2_d;
      last2_q     <= last2_d;
      tdata_q     <= tdata_d;
      tstrb_q     <= tstrb_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

endmodule

// File: tb/tb_fm_mod32.sv
// -----------------------------------------------------------------------------
// tb_fm_mod32 : self-checking bench for fm_mod32. Two instances share the
// stimulus: dut_a with default parameters and dut_b with DEV_SHIFT=16; 'sel'
// routes beats to one of them. A negedge monitor keeps a scoreboard of
// expected {tlast, tstrb, tdata} pushed on every accepted input beat and
// compares on every output handshake; test tasks add explicit value checks.
// -----------------------------------------------------------------------------
module tb_fm_mod32;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;
  bit          rand_ready;

  int n_vec;
  int n_err;
  int in_count;
  int out_count;

  logic [36:0] sb [$];
  logic [31:0] out_log [$];
  logic        last_log [$];
  logic [31:0] model_phi [2];
  logic        hold_valid;
  logic [31:0] hold_data;
  logic        hold_last;

  fm_mod32_if #(.DATA_W(32)) s_a ();
  fm_mod32_if #(.DATA_W(32)) m_a ();
  fm_mod32_if #(.DATA_W(32)) s_b ();
  fm_mod32_if #(.DATA_W(32)) m_b ();

  assign s_a.tvalid = in_valid && !sel;
  assign s_a.tdata  = in_data;
  assign s_a.tlast  = in_last;
  assign s_a.tstrb  = 4'hF;
  assign m_a.tready = out_ready;
  assign s_b.tvalid = in_valid && sel;
  assign s_b.tdata  = in_data;
  assign s_b.tlast  = in_last;
  assign s_b.tstrb  = 4'hF;
  assign m_b.tready = out_ready;

  fm_mod32 dut_a (.s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(s_a), .m00_axis(m_a));
  fm_mod32 #(.DEV_SHIFT(16)) dut_b (.s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(s_b), .m00_axis(m_b));

  logic        s_ready, o_valid, o_last;
  logic [31:0] o_data;
  logic [3:0]  o_strb;
  assign s_ready = sel ? s_b.tready : s_a.tready;
  assign o_valid = sel ? m_b.tvalid : m_a.tvalid;
  assign o_last  = sel ? m_b.tlast  : m_a.tlast;
  assign o_data  = sel ? m_b.tdata  : m_a.tdata;
  assign o_strb  = sel ? m_b.tstrb  : m_a.tstrb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rnd_haz(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else return -$rtoi(0.5 - r);
  endfunction

  // Golden mapping phase -> {Q, I}, evaluated directly on the full circle.
  function automatic logic [31:0] iq_of(input logic [31:0] phi);
    int idx, iv, qv;
    real ang;
    logic [15:0] i16, q16;
    idx = int'(phi[31:20]);
    ang = 2.0 * 3.14159265358979323846 * real'(idx) / 4096.0;
    iv  = rnd_haz(32000.0 * $cos(ang));
    qv  = rnd_haz(32000.0 * $sin(ang));
    i16 = iv[15:0];
    q16 = qv[15:0];
    return {q16, i16};
  endfunction

  function automatic logic [31:0] inc_of(input logic [15:0] x, input int shift);
    logic [31:0] sx;
    sx = {{16{x[15]}}, x};
    return sx << shift;
  endfunction

  // Scoreboard monitor: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    logic [31:0] phi_new;
    logic [36:0] exp_v;
    int          ix;
    if (rst) begin
      sb.delete();
      model_phi[0] = 32'h0;
      model_phi[1] = 32'h0;
      hold_valid   = 1'b0;
    end else begin
      if (hold_valid) begin
        n_vec++;
        if (o_valid !== 1'b1 || o_data !== hold_data || o_last !== hold_last) begin
          n_err++;
          $display("FAIL stall_stable: got v=%b d=%h l=%b, want v=1 d=%h l=%b", o_valid, o_data, o_last, hold_data, hold_last);
        end
      end
      hold_valid = o_valid && !out_ready;
      hold_data  = o_data;
      hold_last  = o_last;
      if (o_valid && out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got %h, want no beat", o_data);
        end else begin
          exp_v = sb.pop_front();
          if ({o_last, o_strb, o_data} !== exp_v) begin
            n_err++;
            $display("FAIL scoreboard: got last=%b strb=%h data=%h, want last=%b strb=%h data=%h",
                     o_last, o_strb, o_data, exp_v[36], exp_v[35:32], exp_v[31:0]);
          end
        end
        out_log.push_back(o_data);
        last_log.push_back(o_last);
        out_count++;
      end
      if (in_valid && s_ready) begin
        ix      = sel ? 1 : 0;
        phi_new = model_phi[ix] + inc_of(in_data[15:0], sel ? 16 : 8);
        sb.push_back({in_last, 4'hF, iq_of(phi_new)});
`ifdef FM_MOD_TLAST_PHASE_RST_EN
        model_phi[ix] = in_last ? 32'h0 : phi_new;
`else
        model_phi[ix] = phi_new;
`endif
        in_count++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one beat and hold it until it is accepted (bounded).
  task automatic send(input logic [15:0] x, input logic last);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = {16'($urandom), x};
    in_last  = last;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = s_ready;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: got no accept in 200 cycles, want accept");
    end
  endtask

  task automatic drain();
    out_ready  = 1'b1;
    rand_ready = 1'b0;
    for (int t = 0; t < 400 && (sb.size() != 0 || o_valid); t++) @(negedge clk);
    @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d beats outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (m_a.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", m_a.tvalid); end
    n_vec++; if (m_a.tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b want 0", m_a.tlast); end
    n_vec++; if (m_a.tdata !== 32'h0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", m_a.tdata); end
    n_vec++; if (m_a.tstrb !== 4'h0) begin n_err++; $display("FAIL reset_tstrb: got %h want 0", m_a.tstrb); end
    n_vec++; if (m_b.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid_b: got %b want 0", m_b.tvalid); end
    n_vec++; if (s_a.tready !== 1'b1) begin n_err++; $display("FAIL reset_tready: got %b want 1", s_a.tready); end
    rst = 1'b0;
    tick();
    n_vec++; if (m_a.tvalid !== 1'b0) begin n_err++; $display("FAIL idle_tvalid: got %b want 0", m_a.tvalid); end
  endtask

  task automatic test_latency();
    do_reset();
    send(16'h0000, 1'b0);
    tick();
    n_vec++; if (m_a.tvalid !== 1'b0) begin n_err++; $display("FAIL latency_early: got %b want 0", m_a.tvalid); end
    tick();
    n_vec++; if (m_a.tvalid !== 1'b1) begin n_err++; $display("FAIL latency_due: got %b want 1", m_a.tvalid); end
    n_vec++; if (m_a.tdata !== 32'h0000_7D00) begin n_err++; $display("FAIL latency_data: got %h want 00007d00", m_a.tdata); end
    drain();
  endtask

  task automatic test_zero();
    do_reset();
    out_log.delete();
    for (int i = 0; i < 8; i++) send(16'h0000, 1'b0);
    drain();
    n_vec++; if (out_log.size() != 8) begin n_err++; $display("FAIL zero_count: got %0d want 8", out_log.size()); end
    for (int i = 0; i < out_log.size(); i++) begin
      n_vec++;
      if (out_log[i] !== 32'h0000_7D00) begin n_err++; $display("FAIL zero_iq[%0d]: got %h want 00007d00", i, out_log[i]); end
    end
  endtask

  task automatic test_dev16();
    logic [31:0] exp_v [5];
    exp_v[0] = 32'h7D00_0000; exp_v[1] = 32'h0000_8300; exp_v[2] = 32'h8300_0000;
    exp_v[3] = 32'h0000_7D00; exp_v[4] = 32'h8300_0000;
    sel = 1'b1;
    do_reset();
    out_log.delete();
    for (int i = 0; i < 4; i++) send(16'h4000, 1'b0);
    send(16'hC000, 1'b0);
    drain();
    n_vec++; if (out_log.size() != 5) begin n_err++; $display("FAIL dev16_count: got %0d want 5", out_log.size()); end
    for (int i = 0; i < 5 && i < out_log.size(); i++) begin
      n_vec++;
      if (out_log[i] !== exp_v[i]) begin n_err++; $display("FAIL dev16_iq[%0d]: got %h want %h", i, out_log[i], exp_v[i]); end
    end
    sel = 1'b0;
  endtask

  task automatic test_quarter_step();
    do_reset();
    out_log.delete();
    for (int i = 0; i < 4; i++) send(16'h4000, 1'b0);
    drain();
    n_vec++;
    if (out_log.size() < 1 || out_log[0] !== 32'h00C4_7CFF) begin
      n_err++; $display("FAIL step4_beat1: got %h want 00c47cff", out_log.size() > 0 ? out_log[0] : 32'hx);
    end
  endtask

  task automatic test_random_stall();
    do_reset();
    in_count = 0; out_count = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(16'($urandom), 1'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
    n_vec++; if (in_count != 1000) begin n_err++; $display("FAIL rand_in_count: got %0d want 1000", in_count); end
    n_vec++; if (out_count != in_count) begin n_err++; $display("FAIL rand_out_count: got %0d want %0d", out_count, in_count); end
  endtask

  task automatic test_tlast();
    logic [15:0] xs [10];
    do_reset();
    out_log.delete();
    last_log.delete();
    for (int i = 0; i < 10; i++) xs[i] = 16'($urandom);
    for (int i = 0; i < 10; i++) send(xs[i], 1'(i == 4));
    drain();
    n_vec++; if (last_log.size() != 10) begin n_err++; $display("FAIL tlast_count: got %0d want 10", last_log.size()); end
    for (int i = 0; i < 10 && i < last_log.size(); i++) begin
      n_vec++;
      if (last_log[i] !== 1'(i == 4)) begin n_err++; $display("FAIL tlast_pos[%0d]: got %b want %b", i, last_log[i], (i == 4)); end
    end
`ifdef FM_MOD_TLAST_PHASE_RST_EN
    n_vec++;
    if (out_log.size() < 6 || out_log[5] !== iq_of(inc_of(xs[5], 8))) begin
      n_err++; $display("FAIL tlast_phase_restart: got %h want %h", out_log.size() > 5 ? out_log[5] : 32'hx, iq_of(inc_of(xs[5], 8)));
    end
`endif
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) send(16'($urandom_range(1, 65535)), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (m_a.tvalid !== 1'b0) begin n_err++; $display("FAIL midreset_tvalid: got %b want 0", m_a.tvalid); end
    out_log.delete();
    send(16'h0000, 1'b0);
    drain();
    n_vec++;
    if (out_log.size() != 1 || out_log[0] !== 32'h0000_7D00) begin
      n_err++; $display("FAIL midreset_restart: got %0d beats first %h, want 1 beat 00007d00", out_log.size(), out_log.size() > 0 ? out_log[0] : 32'hx);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0; in_count = 0; out_count = 0;
    sel = 1'b0; rand_ready = 1'b0; hold_valid = 1'b0;
    test_reset();
    test_latency();
    test_zero();
    test_dev16();
    test_quarter_step();
    test_random_stall();
    test_tlast();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
